// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory: access width codes,
// the position of the unsigned-load flag in mem_op, and the FSM state encoding.
// No logic lives here; the package is imported by dm_lane_align and dm_ext.
package dm_pkg;

    // mem_op[1:0] width codes
    localparam logic [1:0] MEM_W_WORD = 2'b00;
    localparam logic [1:0] MEM_W_HALF = 2'b01;
    localparam logic [1:0] MEM_W_BYTE = 2'b10;
    localparam logic [1:0] MEM_W_RSVD = 2'b11;

    // mem_op bit that selects zero extension on loads
    localparam int MEM_UNSIGNED = 2;

    typedef enum logic {
        DM_CLEAR = 1'b0,
        DM_READY = 1'b1
    } dm_state_t;

endpackage

// File: rtl/dm_lane_align.sv
// Lane steering for sub-word accesses: store merge, load extension, alignment check.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stateless, evaluated every cycle.
// Ports: lane_i/width_i/unsigned_i describe the access, old_word_i is the addressed
// RAM word, din_i the store data; st_word_o is the merged word to write back,
// ld_word_o the extended load result, align_err_o flags misalignment or width 11.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] din_i,
    output logic [31:0] st_word_o,
    output logic [31:0] ld_word_o,
    output logic        align_err_o
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        st_word_o   = old_word_i;
        ld_word_o   = '0;
        align_err_o = 1'b0;
        half_v      = old_word_i[{lane_i[1], 4'b0000} +: 16];
        byte_v      = old_word_i[{lane_i, 3'b000} +: 8];

        case (width_i)
            MEM_W_WORD: begin
                st_word_o   = din_i;
                ld_word_o   = old_word_i;
                align_err_o = (lane_i != 2'b00);
            end
            MEM_W_HALF: begin
                // Only the two lanes selected by lane[1] take the low half of din.
                st_word_o[{lane_i[1], 4'b0000} +: 16] = din_i[15:0];
                ld_word_o   = {{16{~unsigned_i & half_v[15]}}, half_v};
                align_err_o = lane_i[0];
            end
            MEM_W_BYTE: begin
                st_word_o[{lane_i, 3'b000} +: 8] = din_i[7:0];
                ld_word_o   = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            end
            default: begin
                align_err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dm_ext.sv
// MEM-stage data memory with sub-word access, base/range checking and a post-reset clear sweep.
// Latency: combinational reads (zero cycles); writes commit on the rising clk edge.
// Backpressure: busy is high during the clear sweep; stores seen while busy are dropped, not queued.
// Ports: clk/reset (async, active high); pc for the write log; we/mem_op/a/din describe
// the access; dout is the extended load data; busy, align_err, range_err are status.
module dm_ext
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter bit          LOG_WRITES     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] a,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        busy,
    output logic        align_err,
    output logic        range_err
);

    localparam int             AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0]    SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH_WORDS - 1);

    logic [31:0]   mem_q [DEPTH_WORDS];
    dm_state_t     state_q;
    logic [AW-1:0] clr_idx_q;
    logic          busy_q;

    logic [32:0]   diff;
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   st_word;
    logic [31:0]   ld_word;
    logic          wr_en;
    logic          clr_we;

    // A 33-bit subtraction gives "a below base" as the borrow bit, so no
    // comparison against a possibly-zero constant base is needed.
    assign diff      = {1'b0, a} - {1'b0, BASE_ADDR};
    assign off       = diff[31:0];
    assign range_err = diff[32] | ({1'b0, off} >= SPAN);
    assign idx       = off[AW+1:2];
    assign lane      = off[1:0];
    assign rd_word   = mem_q[idx];

    dm_lane_align u_align (
        .lane_i      (lane),
        .width_i     (mem_op[1:0]),
        .unsigned_i  (mem_op[MEM_UNSIGNED]),
        .old_word_i  (rd_word),
        .din_i       (din),
        .st_word_o   (st_word),
        .ld_word_o   (ld_word),
        .align_err_o (align_err)
    );

    assign busy   = busy_q;
    assign dout   = (busy_q | range_err | align_err) ? 32'h0 : ld_word;
    assign wr_en  = we & ~busy_q & ~range_err & ~align_err;
    assign clr_we = (state_q == DM_CLEAR) & ~reset;

    // Clear-sweep FSM. The last word is cleared on the same edge that moves to
    // READY, so the sweep takes exactly DEPTH_WORDS edges and clr_idx never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? DM_CLEAR : DM_READY;
            clr_idx_q <= '0;
            busy_q    <= CLEAR_ON_RESET;
        end else begin
            case (state_q)
                DM_CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= DM_READY;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                DM_READY: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= DM_READY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The array has no reset: contents are either swept to zero or left intact.
    // Sweep and user writes are exclusive because wr_en requires !busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx_q] <= 32'h0;
        end else if (wr_en) begin
            mem_q[idx] <= st_word;
        end
    end

`ifndef SYNTHESIS
    if (LOG_WRITES) begin : g_log
        always @(posedge clk) begin
            if (wr_en && !reset) begin
                $display("%d@%h: *%h <= %h", $time, pc, {a[31:2], 2'b00}, st_word);
            end
        end
    end
`endif

endmodule
